// File: rtl/udp_tx_mux.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_mux
// Purpose  : Round-robin, packet-locked merge of NUM_CHANNELS AXI-Stream
//            TX channels onto one stream that feeds the UDP TX engine.
//            One arbitration cycle runs in IDLE. The winner then keeps the
//            output until its tlast beat is accepted. A single register
//            stage drives the merged output.
// Ports    :
//   tx_axis_aclk          single clock for the whole block
//   tx_axis_aresetn       synchronous active-low reset
//   s_axis_tvalid/tready  per-channel handshake (NUM_CHANNELS bits)
//   s_axis_tlast          per-channel end of packet
//   s_axis_tdata/tkeep    per-channel beat; channel i at slice i*WIDTH
//   s_axis_connection_id  per-channel id, sampled on the first beat only
//   m_axis_*              merged stream; tdest = source channel index
//   m_axis_connection_id  id latched at packet start, held for all beats
//   busy                  high while a packet is locked
//   pkt_count             (only with ZEUS_TX_MUX_STATS_EN) 32-bit per-channel
//                         count of accepted tlast beats
// Config   : `define ZEUS_TX_MUX_STATS_EN adds the pkt_count port and counters
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_mux #(
    parameter int NUM_CHANNELS  = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int CONN_ID_WIDTH = 18,
    localparam int CH_W         = ($clog2(NUM_CHANNELS) > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  tx_axis_aclk,
    input  logic                                  tx_axis_aresetn,
    input  logic [NUM_CHANNELS-1:0]               s_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]               s_axis_tready,
    input  logic [NUM_CHANNELS-1:0]               s_axis_tlast,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [NUM_CHANNELS*CONN_ID_WIDTH-1:0] s_axis_connection_id,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
    output logic [CONN_ID_WIDTH-1:0]              m_axis_connection_id,
    output logic [CH_W-1:0]                       m_axis_tdest,
    output logic                                  busy
`ifdef ZEUS_TX_MUX_STATS_EN
    ,
    output logic [NUM_CHANNELS*32-1:0]            pkt_count
`endif
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_lock = 1'b1;

    logic [0:0]               r_state;
    logic [CH_W-1:0]          r_grant;
    logic [CH_W-1:0]          r_rr_ptr;
    logic [CONN_ID_WIDTH-1:0] r_conn_id;

    logic                     r_m_tvalid;
    logic                     r_m_tlast;
    logic [DATA_WIDTH-1:0]    r_m_tdata;
    logic [KEEP_WIDTH-1:0]    r_m_tkeep;
    logic [CONN_ID_WIDTH-1:0] r_m_conn_id;
    logic [CH_W-1:0]          r_m_tdest;

    logic                     w_found;
    logic [CH_W-1:0]          w_sel;
    logic [NUM_CHANNELS-1:0]  w_tready;
    logic                     w_accept;
    logic                     w_accept_last;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_found && s_axis_tvalid[(int'(r_rr_ptr) + i) % NUM_CHANNELS]) begin
                w_found = 1'b1;
                w_sel   = CH_W'((int'(r_rr_ptr) + i) % NUM_CHANNELS);
            end
        end
    end

    // Only the locked channel sees ready, and only when the output register
    // is empty or draining this cycle. Held low while reset is asserted.
    always_comb begin
        w_tready = '0;
        if (tx_axis_aresetn && (r_state == c_st_lock)) begin
            w_tready[r_grant] = !r_m_tvalid || m_axis_tready;
        end
    end

    assign w_accept      = s_axis_tvalid[r_grant] && w_tready[r_grant];
    assign w_accept_last = w_accept && s_axis_tlast[r_grant];

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            r_state     <= c_st_idle;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_conn_id   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_conn_id <= '0;
            r_m_tdest   <= '0;
        end else begin
            if (r_state == c_st_idle) begin
                if (w_found) begin
                    r_grant   <= w_sel;
                    r_conn_id <= s_axis_connection_id[int'(w_sel)*CONN_ID_WIDTH +: CONN_ID_WIDTH];
                    r_state   <= c_st_lock;
                end
            end else begin
                // Lock is released only by an accepted tlast beat; a granted
                // channel that drops tvalid simply stalls the packet.
                if (w_accept_last) begin
                    r_state  <= c_st_idle;
                    r_rr_ptr <= (r_grant == CH_W'(NUM_CHANNELS - 1)) ? '0 : r_grant + CH_W'(1);
                end
            end

            if (w_accept) begin
                r_m_tvalid  <= 1'b1;
                r_m_tlast   <= s_axis_tlast[r_grant];
                r_m_tdata   <= s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
                r_m_tkeep   <= s_axis_tkeep[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
                r_m_conn_id <= r_conn_id;
                r_m_tdest   <= r_grant;
            end else if (m_axis_tready) begin
                r_m_tvalid  <= 1'b0;
            end
        end
    end

    assign s_axis_tready        = w_tready;
    assign m_axis_tvalid        = r_m_tvalid;
    assign m_axis_tlast         = r_m_tlast;
    assign m_axis_tdata         = r_m_tdata;
    assign m_axis_tkeep         = r_m_tkeep;
    assign m_axis_connection_id = r_m_conn_id;
    assign m_axis_tdest         = r_m_tdest;
    assign busy                 = (r_state == c_st_lock);

`ifdef ZEUS_TX_MUX_STATS_EN
    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_stats
            logic [31:0] r_cnt;
            always_ff @(posedge tx_axis_aclk) begin
                if (!tx_axis_aresetn) begin
                    r_cnt <= '0;
                end else if (w_accept_last && (r_grant == CH_W'(g))) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign pkt_count[g*32 +: 32] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire
